ldl_rr_arbiter: RTL

- Round-robin arbiter that shares one resource between N = 2**IDX_WIDTH requesters.
- Winner is tracked as a registered binary index; the one-hot grant vector is decoded from that index by a binary-to-one-hot decoder instance.
- Supports hold-until-release ownership, optional preemption after HOLD_MAX cycles, and a global enable gating new grants.
- Sits in front of any shared bus, port or engine in the library.

---
 rtl/ldl_arb_pkg.sv | 41 ++++
 rtl/LDL_bin2hot.sv | 20 ++
 rtl/ldl_rr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/ldl_arb_pkg.sv
// Shared types and the rotating-priority search used by the round-robin arbiter.
package ldl_arb_pkg;

    // Upper bound on requester index width that rr_pick can scan.
    localparam int ARB_IDX_MAX = 8;
    localparam int ARB_N_MAX   = 1 << ARB_IDX_MAX;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                   found;
        logic [ARB_IDX_MAX-1:0] idx;
    } rr_pick_t;

    // Return the first requester at or after ptr (wrapping modulo n) whose
    // req bit is set and whose mask bit allows it. n must be a power of two.
    function automatic rr_pick_t rr_pick(
        input logic [ARB_N_MAX-1:0]   req,
        input logic [ARB_IDX_MAX-1:0] ptr,
        input logic [ARB_N_MAX-1:0]   mask,
        input int unsigned            n
    );
        rr_pick_t               res;
        logic [ARB_N_MAX-1:0]   cand;
        logic [ARB_IDX_MAX-1:0] pos;
        res  = '0;
        cand = req & mask;
        for (int unsigned i = 0; i < ARB_N_MAX; i++) begin
            pos = ARB_IDX_MAX'((32'(ptr) + i) & (n - 1));
            if (i < n && !res.found && cand[pos]) begin
                res.found = 1'b1;
                res.idx   = pos;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/LDL_bin2hot.sv
// Binary-to-one-hot decoder with an enable that forces the output to zero.
module LDL_bin2hot #(
    parameter int BIN_WIDTH = 2
) (
    input  logic                      en,
    input  logic [BIN_WIDTH-1:0]      x,
    output logic [(1<<BIN_WIDTH)-1:0] y
);

    // Decode x to a single set bit, or all zeros when disabled.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise the untaken path holds the old value and infers a latch.
        y = '0;
        if (en) begin
            y[x] = 1'b1;
        end
    end

endmodule

// File: rtl/ldl_rr_arbiter.sv
// Round-robin arbiter: registered binary owner index, one-hot grant decoded
// from it, hold-until-release ownership with optional tenure limit.
module ldl_rr_arbiter
    import ldl_arb_pkg::*;
#(
    parameter int IDX_WIDTH = 2,   // at most ARB_IDX_MAX
    parameter int HOLD_MAX  = 0    // 0 = owner keeps grant until release
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [(1<<IDX_WIDTH)-1:0] req,
    output logic [(1<<IDX_WIDTH)-1:0] gnt,
    output logic [IDX_WIDTH-1:0]      gnt_idx,
    output logic                      gnt_vld
);

    localparam int unsigned N_REQ = 1 << IDX_WIDTH;
    localparam int          HCW   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    // Last tenure cycle before a pending competitor takes over.
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);
    localparam logic [HCW-1:0] HOLD_SAT  = HCW'(HOLD_MAX);

    arb_state_t           r_state;
    logic [IDX_WIDTH-1:0] r_gnt_idx;
    logic                 r_gnt_vld;
    logic [IDX_WIDTH-1:0] r_ptr;
    logic [HCW-1:0]       r_hold_cnt;

    logic [N_REQ-1:0]     w_allow;
    logic                 w_owner_req;
    rr_pick_t             w_pick;
    logic                 w_found;
    logic [IDX_WIDTH-1:0] w_win_idx;
    logic                 w_preempt;
    logic                 w_new_grant;
    logic                 w_unused_pick;

    // One-hot grant is a pure decode of the registered owner index.
    LDL_bin2hot #(
        .BIN_WIDTH (IDX_WIDTH)
    ) u_bin2hot (
        .en (r_gnt_vld),
        .x  (r_gnt_idx),
        .y  (gnt)
    );

    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;

    // Candidate search: the current owner (if any) is never its own successor.
    always_comb begin
        w_allow     = ~gnt;
        w_owner_req = |(req & gnt);
        w_pick      = rr_pick(ARB_N_MAX'(req), ARB_IDX_MAX'(r_ptr),
                              ARB_N_MAX'(w_allow), N_REQ);
        w_found     = w_pick.found;
        w_win_idx   = w_pick.idx[IDX_WIDTH-1:0];
    end

    // Upper index bits are always zero for this width.
    assign w_unused_pick = ^w_pick.idx;

    // Arbitration points: idle request, owner release, or tenure expiry.
    always_comb begin
        w_preempt   = (HOLD_MAX != 0) && (r_state == GRANT) && w_owner_req &&
                      (r_hold_cnt == HOLD_LAST) && en && w_found;
        w_new_grant = en && w_found &&
                      ((r_state == IDLE) || !w_owner_req || w_preempt);
    end

    // Arbitration FSM: owner index, rotation pointer and tenure counter.
    // NOTE: the reset branch is asynchronous, so grants drop the instant rst
    // rises rather than at the next clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt_idx  <= '0;
            r_gnt_vld  <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else if (w_new_grant) begin
            // NOTE: non-blocking assignments so every register here updates
            // from the same pre-edge values regardless of statement order.
            r_state    <= GRANT;
            r_gnt_idx  <= w_win_idx;
            r_gnt_vld  <= 1'b1;
            r_ptr      <= w_win_idx + 1'b1;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_hold_cnt <= '0;
                end
                GRANT: begin
                    if (!w_owner_req) begin
                        r_state    <= IDLE;
                        r_gnt_idx  <= '0;
                        r_gnt_vld  <= 1'b0;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt != HOLD_SAT) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_gnt_idx <= '0;
                    r_gnt_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
